divshiftsub: RTL and testbench
==============================

# divshiftsub

Multi-cycle sequential fixed-point divider for the EMA path of the synchronisation module. It computes `(dividend << FRACBITS) / divisor` by restoring shift-subtract, one quotient bit per 4-cycle iteration. It is the inverse counterpart of the EMA shift-add multiplier and uses the same start/finish handshake toward the EMA controller. Dividend is signed two's complement, divisor is unsigned, and the quotient is signed, truncated toward zero and saturated.

## Interface
- `WIDTH`, default 16: data width of dividend, divisor and quotient.
- `FRACBITS`, default 8: fractional bits of the quotient scaling; iteration count `K = WIDTH + FRACBITS`.
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `ema_divshiftsub_start`, input, 1: start request; sampled only in IDLE.
- `ema_divshiftsub_dividend`, input, WIDTH: signed dividend; sampled with start.
- `ema_divshiftsub_divisor`, input, WIDTH: unsigned divisor; sampled with start.
- `divshiftsub_ema_finish`, output, 1: one-cycle pulse in FIN.
- `divshiftsub_ema_quotient`, output, WIDTH: result; valid only while finish=1, 0 otherwise.
- `divshiftsub_ema_divzero`, output, 1: divide-by-zero flag; valid only while finish=1, 0 otherwise.
- `divshiftsub_ema_busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, SUB, DEC, TESTCNT0, SIGN, FIN.
- Registers:
  - `n_r`: numerator, K bits.
  - `r_r`: partial remainder, WIDTH+1 bits.
  - `d_r`: divisor, WIDTH bits.
  - `q_r`: quotient, K bits, plus 1 guard bit under ROUND.
  - `neg_r`: result sign.
  - `dz_r`: divide-by-zero flag.
  - `counter_r`: iteration counter.
- **IDLE**, start=1 and divisor ≠ 0:
  - Load `n_r = |dividend| << FRACBITS`. `|dividend|` is taken as a WIDTH-bit unsigned value, so 0x8000 gives 32768.
  - Load `neg_r = dividend[WIDTH-1]`, `d_r = divisor`, `r_r = 0`, `q_r = 0`.
  - Load `counter_r = K` (K+1 under ROUND). Next state: SHIFT.
- **IDLE**, start=1 and divisor = 0:
  - Load `dz_r = 1` and `neg_r = dividend[WIDTH-1]`. Next state: FIN.
- **SHIFT**:
  - `r_r = {r_r[WIDTH-1:0], n_r[K-1]}`.
  - `n_r = n_r << 1`.
  - `q_r = q_r << 1`.
- **SUB**:
  - If `r_r >= d_r`: `r_r = r_r - d_r` and `q_r[0] = 1`.
  - Otherwise: no change.
- **DEC**: `counter_r = counter_r - 1`.
- **TESTCNT0**: if `counter_r == 0`, go to SIGN; otherwise go to SHIFT.
- **SIGN**:
  - Saturate the magnitude to `2^(WIDTH-1)-1` if positive, or to `2^(WIDTH-1)` if negative.
  - Negate the result if `neg_r`.
  - Store it in `q_r`.
- **FIN**:
  - Drive `finish=1`, `quotient = q_r[WIDTH-1:0]` and `divzero = dz_r`.
  - On divide-by-zero, quotient is 0x7FFF… if the dividend was non-negative, 0x80… if negative.
  - Next state: IDLE; clear `dz_r`.
- A zero dividend always yields quotient 0.
- Start is ignored in every state except IDLE; no queuing.
- Start may be asserted in the cycle right after FIN; it is then accepted normally.
- Operand inputs may change freely after the start cycle.

## Timing
- Reset: `state = IDLE` and all registers 0. Reset values of outputs:
  - finish = 0
  - quotient = 0
  - divzero = 0
  - busy = 0
- Reset wins over every other event, including start in the same cycle and mid-division; an in-flight result is discarded with no finish.
- Start accepted at edge 0. Normal-case states by cycle:
  - Iterations occupy cycles 1..4K.
  - SIGN occupies cycle 4K+1.
  - FIN occupies cycle 4K+2, so finish is high in cycle 4K+2: 98 cycles for the defaults.
- Under ROUND: FIN in cycle 4(K+1)+2, i.e. 102 cycles for the defaults.
- Divide-by-zero: FIN in cycle 1.
- busy is high from cycle 1 through FIN inclusive and low in the cycle after FIN.

## Configuration
- `DIVSHIFTSUB_ROUND_EN` defined:
  - One extra iteration produces a guard bit.
  - SIGN forms `(q+1)>>1` on the magnitude before saturation, i.e. round half away from zero.
  - Latency grows by 4 cycles.
- Undefined: K iterations, truncation toward zero.
- Divide-by-zero behaviour and the interface are identical in both builds.

## Test plan
All cases use WIDTH=16, FRACBITS=8.
- dividend 0x0300, divisor 0x0200, start → finish exactly 98 cycles later, quotient 0x0180, divzero 0, busy low the next cycle.
- dividend 0xFD00, divisor 0x0200 → quotient 0xFE80.
- dividend 0x0002, divisor 3:
  - Without the macro: quotient 0x00AA.
  - With `DIVSHIFTSUB_ROUND_EN`: 0x00AB at cycle 102.
- dividend 0xFFFE, divisor 3:
  - Without the macro: quotient 0xFF56.
  - With the macro: 0xFF55.
- Saturation:
  - dividend 0x7FFF, divisor 1 → 0x7FFF.
  - dividend 0x8000, divisor 1 → 0x8000.
  - divzero 0 in both cases.
- Divide-by-zero:
  - dividend 0xFF00, divisor 0 → finish in cycle 1, quotient 0x8000, divzero 1.
  - dividend 0x0100, divisor 0 → quotient 0x7FFF.
- Busy and reset:
  - A second start at cycle 10 is ignored; a single finish follows with the first result.
  - rst at cycle 40 → no finish; all outputs 0 the next cycle; a fresh start is accepted immediately afterwards.

Source files
------------

// File: rtl/divshiftsub_if.sv
// Start/finish bus between the EMA controller and the shift-subtract divider.
// Parameterised by the operand/quotient width.
interface divshiftsub_if #(
    parameter int WIDTH = 16
);
    // Handshake: start is a one-cycle request taken only while busy=0; the
    // operands are sampled on the same edge and may change afterwards.
    // finish is a one-cycle pulse, and quotient/divzero are meaningful only
    // while it is high.
    logic             ema_divshiftsub_start;
    logic [WIDTH-1:0] ema_divshiftsub_dividend;
    logic [WIDTH-1:0] ema_divshiftsub_divisor;
    logic             divshiftsub_ema_finish;
    logic [WIDTH-1:0] divshiftsub_ema_quotient;
    logic             divshiftsub_ema_divzero;
    logic             divshiftsub_ema_busy;

    modport master (
        output ema_divshiftsub_start, ema_divshiftsub_dividend, ema_divshiftsub_divisor,
        input  divshiftsub_ema_finish, divshiftsub_ema_quotient, divshiftsub_ema_divzero,
               divshiftsub_ema_busy
    );

    modport slave (
        input  ema_divshiftsub_start, ema_divshiftsub_dividend, ema_divshiftsub_divisor,
        output divshiftsub_ema_finish, divshiftsub_ema_quotient, divshiftsub_ema_divzero,
               divshiftsub_ema_busy
    );
endinterface

// File: rtl/divshiftsub.sv
// Restoring shift-subtract divider: (dividend << FRACBITS) / divisor, signed, saturated.
// Define DIVSHIFTSUB_ROUND_EN for a guard-bit iteration and round half away from zero.
module divshiftsub #(
    parameter int WIDTH    = 16,
    parameter int FRACBITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    divshiftsub_if.slave bus,
    output logic [2:0]   state_o
);
    localparam int K  = WIDTH + FRACBITS;
`ifdef DIVSHIFTSUB_ROUND_EN
    localparam int QW = K + 1;
`else
    localparam int QW = K;
`endif
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        SUB      = 3'd2,
        DEC      = 3'd3,
        TESTCNT0 = 3'd4,
        SIGN     = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [K-1:0]     n_q, n_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [QW-1:0]    q_q, q_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] abs_dividend;
    logic [QW:0]      mag;
    logic [QW:0]      lim;
    logic [WIDTH-1:0] sat_mag;
    logic [WIDTH-1:0] signed_res;

    // Magnitude as an unsigned WIDTH-bit value, so the most negative input maps to 2^(WIDTH-1).
    always_comb begin
        abs_dividend = bus.ema_divshiftsub_dividend[WIDTH-1] ? -bus.ema_divshiftsub_dividend
                                                             : bus.ema_divshiftsub_dividend;
`ifdef DIVSHIFTSUB_ROUND_EN
        mag = ({1'b0, q_q} + (QW+1)'(1)) >> 1;
`else
        mag = {1'b0, q_q};
`endif
        lim = {{(QW+1-WIDTH){1'b0}}, neg_q, {(WIDTH-1){~neg_q}}};
        sat_mag    = (mag > lim) ? lim[WIDTH-1:0] : mag[WIDTH-1:0];
        signed_res = neg_q ? -sat_mag : sat_mag;
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ema_divshiftsub_start) begin
                    neg_d = bus.ema_divshiftsub_dividend[WIDTH-1];
                    if (bus.ema_divshiftsub_divisor == '0) begin
                        // Divide-by-zero goes straight to FIN with the saturated extreme preloaded.
                        dz_d    = 1'b1;
                        q_d     = {{(QW-WIDTH){1'b0}}, bus.ema_divshiftsub_dividend[WIDTH-1],
                                   {(WIDTH-1){~bus.ema_divshiftsub_dividend[WIDTH-1]}}};
                        state_d = FIN;
                    end else begin
                        n_d     = {abs_dividend, {FRACBITS{1'b0}}};
                        d_d     = bus.ema_divshiftsub_divisor;
                        r_d     = '0;
                        q_d     = '0;
                        cnt_d   = CW'(QW);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                r_d     = {r_q[WIDTH-1:0], n_q[K-1]};
                n_d     = {n_q[K-2:0], 1'b0};
                q_d     = {q_q[QW-2:0], 1'b0};
                state_d = SUB;
            end
            SUB: begin
                if (r_q >= {1'b0, d_q}) begin
                    r_d    = r_q - {1'b0, d_q};
                    q_d[0] = 1'b1;
                end
                state_d = DEC;
            end
            DEC: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = TESTCNT0;
            end
            TESTCNT0: state_d = (cnt_q == '0) ? SIGN : SHIFT;
            SIGN: begin
                q_d     = {{(QW-WIDTH){1'b0}}, signed_res};
                state_d = FIN;
            end
            FIN: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.divshiftsub_ema_finish   = (state_q == FIN);
        bus.divshiftsub_ema_quotient = (state_q == FIN) ? q_q[WIDTH-1:0] : '0;
        bus.divshiftsub_ema_divzero  = (state_q == FIN) ? dz_q : 1'b0;
        bus.divshiftsub_ema_busy     = (state_q != IDLE);
        state_o                      = state_q;
    end
endmodule

// File: tb/tb_divshiftsub.sv
// Directed bench for divshiftsub (WIDTH=16, FRACBITS=8) with hand-computed results.
module tb_divshiftsub;
  localparam int W = 16;
`ifdef DIVSHIFTSUB_ROUND_EN
  localparam int LAT = 102;
  localparam logic [W-1:0] Q_2_3  = 16'h00AB;
  localparam logic [W-1:0] Q_M2_3 = 16'hFF55;
`else
  localparam int LAT = 98;
  localparam logic [W-1:0] Q_2_3  = 16'h00AA;
  localparam logic [W-1:0] Q_M2_3 = 16'hFF56;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  int         checks;
  int         errors;
  logic [W:0] exp_q[$];

  divshiftsub_if #(.WIDTH(W)) bus ();

  divshiftsub #(.WIDTH(W), .FRACBITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; start is taken on the next rising edge (edge 0).
  task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    bus.ema_divshiftsub_start    = 1'b1;
    bus.ema_divshiftsub_dividend = dvd;
    bus.ema_divshiftsub_divisor  = dvs;
    @(posedge clk);
    #1;
    bus.ema_divshiftsub_start    = 1'b0;
    bus.ema_divshiftsub_dividend = W'($urandom);
    bus.ema_divshiftsub_divisor  = W'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic [W-1:0] exp_quo, input logic exp_dz, input int exp_lat);
    int cyc;
    bit seen;
    logic [W:0] e;
    seen = 1'b0;
    cyc  = 0;
    exp_q.push_back({exp_dz, exp_quo});
    start_op(dvd, dvs);
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy_c1"}, 32'(bus.divshiftsub_ema_busy), 32'd1);
      if (bus.divshiftsub_ema_finish) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, " quotient"}, 32'(bus.divshiftsub_ema_quotient), 32'(e[W-1:0]));
      check({tag, " divzero"}, 32'(bus.divshiftsub_ema_divzero), 32'(e[W]));
      @(negedge clk);
      check({tag, " busy_after"}, 32'(bus.divshiftsub_ema_busy), 32'd0);
      check({tag, " finish_after"}, 32'(bus.divshiftsub_ema_finish), 32'd0);
    end
  endtask

  initial begin
    int nfin;
    int fin_cyc;
    logic [W-1:0] fin_quo;
    logic fin_dz;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ema_divshiftsub_start    = 1'b1;
    bus.ema_divshiftsub_dividend = 16'h0300;
    bus.ema_divshiftsub_divisor  = 16'h0200;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst finish", 32'(bus.divshiftsub_ema_finish), 32'd0);
    check("rst busy", 32'(bus.divshiftsub_ema_busy), 32'd0);
    bus.ema_divshiftsub_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle quotient", 32'(bus.divshiftsub_ema_quotient), 32'd0);
    check("idle divzero", 32'(bus.divshiftsub_ema_divzero), 32'd0);
    check("idle state", 32'(state_dbg), 32'd0);

    run_op("p3_2",   16'h0300, 16'h0200, 16'h0180, 1'b0, LAT);
    run_op("m3_2",   16'hFD00, 16'h0200, 16'hFE80, 1'b0, LAT);
    run_op("p2_3",   16'h0002, 16'h0003, Q_2_3,    1'b0, LAT);
    run_op("m2_3",   16'hFFFE, 16'h0003, Q_M2_3,   1'b0, LAT);
    run_op("satpos", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, LAT);
    run_op("satneg", 16'h8000, 16'h0001, 16'h8000, 1'b0, LAT);
    run_op("zero",   16'h0000, 16'h0007, 16'h0000, 1'b0, LAT);
    run_op("dzneg",  16'hFF00, 16'h0000, 16'h8000, 1'b1, 1);
    run_op("dzpos",  16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1);

    // second start at cycle 10 must be ignored
    nfin = 0;
    fin_cyc = 0;
    fin_quo = '0;
    fin_dz = 1'b0;
    start_op(16'h0300, 16'h0200);
    for (int c = 1; c <= LAT + 10; c++) begin
      @(negedge clk);
      if (bus.divshiftsub_ema_finish) begin
        nfin++;
        fin_cyc = c;
        fin_quo = bus.divshiftsub_ema_quotient;
        fin_dz  = bus.divshiftsub_ema_divzero;
      end
      if (c == 10) begin
        bus.ema_divshiftsub_start    = 1'b1;
        bus.ema_divshiftsub_dividend = 16'h0100;
        bus.ema_divshiftsub_divisor  = 16'h0000;
      end else begin
        bus.ema_divshiftsub_start = 1'b0;
      end
    end
    check("ign count", 32'(nfin), 32'd1);
    check("ign latency", 32'(fin_cyc), 32'(LAT));
    check("ign quotient", 32'(fin_quo), 32'h0180);
    check("ign divzero", 32'(fin_dz), 32'd0);

    // reset in cycle 40 discards the in-flight division
    nfin = 0;
    start_op(16'hFD00, 16'h0200);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.divshiftsub_ema_finish) nfin++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst40 nofin", 32'(nfin), 32'd0);
    check("rst40 finish", 32'(bus.divshiftsub_ema_finish), 32'd0);
    check("rst40 quotient", 32'(bus.divshiftsub_ema_quotient), 32'd0);
    check("rst40 divzero", 32'(bus.divshiftsub_ema_divzero), 32'd0);
    check("rst40 busy", 32'(bus.divshiftsub_ema_busy), 32'd0);
    run_op("after_rst", 16'h0002, 16'h0003, Q_2_3, 1'b0, LAT);
    run_op("b2b",       16'hFD00, 16'h0200, 16'hFE80, 1'b0, LAT);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
